spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of flops in each input synchronizer (minimum 2).
REQ-002 SHALL have port clk_i  input  1  system clock; the only clock in the block.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port spi_sclk_i  input  1  SPI clock from pad, asynchronous to clk_i.
REQ-005 SHALL have port spi_cs_i  input  1  SPI chip select from pad, active-low, asynchronous.
REQ-006 SHALL have port spi_mosi_i  input  1  SPI data in from pad, asynchronous.
REQ-007 SHALL have port spi_miso_o  output  1  SPI data out to pad.
REQ-008 SHALL have port rx_data_o  output  8  last fully received byte.
REQ-009 SHALL have port rx_valid_o  output  1  one-cycle strobe qualifying rx_data_o.
REQ-010 SHALL have port tx_data_i  input  8  next byte to transmit.
REQ-011 SHALL have port tx_valid_i  input  1  tx_data_i valid.
REQ-012 SHALL have port tx_ready_o  output  1  TX holding buffer empty; transfer occurs when tx_valid_i and tx_ready_o are both high.
REQ-013 SHALL have port frame_start_o  output  1  one-cycle strobe on CS assertion.
REQ-014 SHALL have port frame_end_o  output  1  one-cycle strobe on CS deassertion.
REQ-015 SHALL have port tx_underrun_o  output  1  one-cycle strobe when a byte load finds the holding buffer empty.

Function
REQ-016 SHALL pass spi_sclk_i, spi_cs_i and spi_mosi_i each through SYNC_STAGES flops clocked by clk_i, and use only the synchronized copies.
REQ-017 SHALL detect rise/fall edges of synchronized SCLK and CS by comparison with a one-cycle-delayed copy.
REQ-018 SHALL implement SPI mode 0: MOSI sampled on SCLK rise, MISO updated on SCLK fall, MSB first.
REQ-019 SHALL support SCLK frequency up to clk_i/4; behaviour above that is undefined.
REQ-020 SHALL implement FSM states IDLE and ACTIVE; IDLE->ACTIVE on CS fall, ACTIVE->IDLE on CS rise; in IDLE SCLK edges are ignored.
REQ-021 SHALL, on IDLE->ACTIVE, clear the 3-bit bit counter, pulse frame_start_o, and load the TX shift register (REQ-025).
REQ-022 SHALL, on each SCLK rise in ACTIVE, shift synchronized MOSI into the RX shift register LSB and increment the bit counter modulo 8.
REQ-023 SHALL, on the SCLK rise completing bit 8 (counter wraps 7->0), register the byte into rx_data_o and pulse rx_valid_o the following clk_i cycle; no backpressure exists and the next byte overwrites.
REQ-024 SHALL, on each SCLK fall in ACTIVE, shift the TX shift register left if the counter is nonzero, else perform a byte load (REQ-025).
REQ-025 SHALL, on a byte load, take the holding buffer if full (then mark empty), else load 8'h00 and pulse tx_underrun_o.
REQ-026 SHALL drive spi_miso_o from TX shift register bit 7 at all times.
REQ-027 SHALL drive tx_ready_o high exactly when the holding buffer is empty; a handshake in the same cycle as a byte load SHALL be accepted after the load, i.e. fill the buffer for the next byte.
REQ-028 SHALL, on CS rise mid-byte, discard the partial RX byte (no rx_valid_o), clear the bit counter, pulse frame_end_o, and keep the holding buffer contents.
REQ-029 SHALL treat CS fall and SCLK edge in the same cycle as CS fall only; an SCLK edge coincident with CS rise SHALL be ignored.

Reset
REQ-030 SHALL, while rst_i is high at a clk_i edge, set FSM to IDLE, counter 0, all shift registers, rx_data_o and synchronizer flops to 0, holding buffer empty (tx_ready_o=1), and all strobes 0; spi_miso_o is therefore 0.
REQ-031 SHALL, when rst_i asserts mid-frame, abandon the frame without frame_end_o and require a new CS fall before further activity.

Verification
REQ-032 SHALL verify: CS low, master sends 8'hA5 at clk/8 -> one rx_valid_o with rx_data_o=8'hA5, frame_start_o then frame_end_o once each.
REQ-033 SHALL verify: tx_data_i=8'h3C handshaken before CS fall, one byte clocked -> master reads 8'h3C on MISO; tx_ready_o returns high after load.
REQ-034 SHALL verify: two-byte frame, second TX byte never supplied -> second MISO byte 8'h00, one tx_underrun_o pulse.
REQ-035 SHALL verify: CS raised after 5 SCLK rises -> no rx_valid_o, frame_end_o pulses, next frame byte 8'h81 received correctly.
REQ-036 SHALL verify: rst_i pulsed after bit 3 of a frame -> all outputs at reset values, no strobes, subsequent frame 8'h5A received correctly.
REQ-037 SHALL verify: back-to-back bytes 8'h01,8'hFF,8'h80 with tx_valid_i held high -> three rx_valid_o with matching data, no underrun.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target: pad inputs are synchronized into clk_i, and the shifting runs on detected SCLK/CS edges.
// A one-byte holding buffer with a valid/ready handshake feeds the transmitter.
module spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sclk_i,
    input  logic       spi_cs_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       frame_start_o,
    output logic       frame_end_o,
    output logic       tx_underrun_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic [7:0]             hold_data;
    logic                   hold_full;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic load_req;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // A byte load happens at frame start and on the SCLK fall that begins each new byte.
    assign load_req = ((state == IDLE) && cs_fall) ||
                      ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == 3'd0));

    assign spi_miso_o = tx_shift[7];
    assign tx_ready_o = ~hold_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            rx_shift      <= 8'h00;
            tx_shift      <= 8'h00;
            hold_data     <= 8'h00;
            hold_full     <= 1'b0;
            rx_data_o     <= 8'h00;
            rx_valid_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            tx_underrun_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state         <= ACTIVE;
                        bit_cnt       <= 3'd0;
                        frame_start_o <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        bit_cnt     <= 3'd0;
                        rx_shift    <= 8'h00;
                        frame_end_o <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_o  <= {rx_shift[6:0], mosi_s};
                            rx_valid_o <= 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase

            if (load_req) begin
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift      <= 8'h00;
                    tx_underrun_o <= 1'b1;
                end
            end

            // Placed after the load so a same-cycle handshake refills the buffer for the next byte.
            if (tx_valid_i && !hold_full) begin
                hold_data <= tx_data_i;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a behavioural SPI master at clk/8 plus strobe counters.
module tb_spi_target;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       spi_sclk_i = 1'b0;
    logic       spi_cs_i = 1'b1;
    logic       spi_mosi_i = 1'b0;
    logic       spi_miso_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic       frame_start_o;
    logic       frame_end_o;
    logic       tx_underrun_o;

    int checks = 0;
    int fails = 0;
    int rx_count = 0;
    int fs_count = 0;
    int fe_count = 0;
    int ur_count = 0;
    logic [7:0] rx_log [0:15];

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .spi_sclk_i(spi_sclk_i), .spi_cs_i(spi_cs_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .tx_underrun_o(tx_underrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            rx_log[rx_count % 16] = rx_data_o;
            rx_count = rx_count + 1;
        end
        if (frame_start_o) fs_count = fs_count + 1;
        if (frame_end_o)   fe_count = fe_count + 1;
        if (tx_underrun_o) ur_count = ur_count + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_frame();
        spi_cs_i = 1'b0;
        repeat (8) @(negedge clk_i);
    endtask

    // CS rises while SCLK is still high after the final bit, so no trailing byte load occurs.
    task automatic end_frame();
        spi_cs_i = 1'b1;
        repeat (4) @(negedge clk_i);
        spi_sclk_i = 1'b0;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit last,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi_i = mo[i];
            repeat (4) @(negedge clk_i);
            mi[i] = spi_miso_o;
            spi_sclk_i = 1'b1;
            repeat (4) @(negedge clk_i);
            if (!(last && i == 0)) spi_sclk_i = 1'b0;
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk_i);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if (tx_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_tx_ready got %b want 1", tx_ready_o); end
        checks++; if (spi_miso_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_miso got %b want 0", spi_miso_o); end
        checks++; if (rx_data_o !== 8'h00) begin fails++; $display("[TB] FAIL reset_rx_data got %h want 00", rx_data_o); end
        checks++; if ({rx_valid_o, frame_start_o, frame_end_o, tx_underrun_o} !== 4'b0000) begin
            fails++; $display("[TB] FAIL reset_strobes got %b want 0000", {rx_valid_o, frame_start_o, frame_end_o, tx_underrun_o});
        end
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        checks++; if (fs_count + fe_count + rx_count + ur_count !== 0) begin
            fails++; $display("[TB] FAIL post_reset_quiet got %0d strobes want 0", fs_count + fe_count + rx_count + ur_count);
        end
    endtask

    task automatic test_rx_basic();
        logic [7:0] mi;
        int rx0 = rx_count, fs0 = fs_count, fe0 = fe_count;
        start_frame();
        spi_bits(8'hA5, 8, 1'b1, mi);
        end_frame();
        checks++; if (rx_count - rx0 !== 1) begin fails++; $display("[TB] FAIL rx_basic_count got %0d want 1", rx_count - rx0); end
        checks++; if (rx_data_o !== 8'hA5) begin fails++; $display("[TB] FAIL rx_basic_data got %h want a5", rx_data_o); end
        checks++; if (fs_count - fs0 !== 1) begin fails++; $display("[TB] FAIL rx_basic_start got %0d want 1", fs_count - fs0); end
        checks++; if (fe_count - fe0 !== 1) begin fails++; $display("[TB] FAIL rx_basic_end got %0d want 1", fe_count - fe0); end
        checks++; if (mi !== 8'h00) begin fails++; $display("[TB] FAIL rx_basic_miso_empty got %h want 00", mi); end
    endtask

    task automatic test_tx();
        logic [7:0] mi;
        int ur0 = ur_count;
        push_tx(8'h3C);
        checks++; if (tx_ready_o !== 1'b0) begin fails++; $display("[TB] FAIL tx_ready_full got %b want 0", tx_ready_o); end
        start_frame();
        checks++; if (tx_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL tx_ready_after_load got %b want 1", tx_ready_o); end
        spi_bits(8'h00, 8, 1'b1, mi);
        end_frame();
        checks++; if (mi !== 8'h3C) begin fails++; $display("[TB] FAIL tx_miso_byte got %h want 3c", mi); end
        checks++; if (ur_count - ur0 !== 0) begin fails++; $display("[TB] FAIL tx_underrun got %0d want 0", ur_count - ur0); end
    endtask

    task automatic test_underrun();
        logic [7:0] mi0, mi1;
        int ur0 = ur_count;
        push_tx(8'h96);
        start_frame();
        spi_bits(8'h11, 8, 1'b0, mi0);
        spi_bits(8'h22, 8, 1'b1, mi1);
        end_frame();
        checks++; if (mi0 !== 8'h96) begin fails++; $display("[TB] FAIL underrun_first got %h want 96", mi0); end
        checks++; if (mi1 !== 8'h00) begin fails++; $display("[TB] FAIL underrun_second got %h want 00", mi1); end
        checks++; if (ur_count - ur0 !== 1) begin fails++; $display("[TB] FAIL underrun_count got %0d want 1", ur_count - ur0); end
        checks++; if (rx_data_o !== 8'h22) begin fails++; $display("[TB] FAIL underrun_rx got %h want 22", rx_data_o); end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int rx0 = rx_count, fe0 = fe_count;
        start_frame();
        spi_bits(8'hF0, 5, 1'b0, mi);
        end_frame();
        checks++; if (rx_count - rx0 !== 0) begin fails++; $display("[TB] FAIL abort_rx_count got %0d want 0", rx_count - rx0); end
        checks++; if (fe_count - fe0 !== 1) begin fails++; $display("[TB] FAIL abort_frame_end got %0d want 1", fe_count - fe0); end
        rx0 = rx_count;
        start_frame();
        spi_bits(8'h81, 8, 1'b1, mi);
        end_frame();
        checks++; if (rx_count - rx0 !== 1) begin fails++; $display("[TB] FAIL abort_next_count got %0d want 1", rx_count - rx0); end
        checks++; if (rx_data_o !== 8'h81) begin fails++; $display("[TB] FAIL abort_next_data got %h want 81", rx_data_o); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi;
        int rx0, fs0, fe0, ur0;
        push_tx(8'hE7);
        start_frame();
        spi_bits(8'hC0, 3, 1'b0, mi);
        rx0 = rx_count; fs0 = fs_count; fe0 = fe_count; ur0 = ur_count;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (tx_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL midrst_tx_ready got %b want 1", tx_ready_o); end
        checks++; if (spi_miso_o !== 1'b0) begin fails++; $display("[TB] FAIL midrst_miso got %b want 0", spi_miso_o); end
        checks++; if (rx_data_o !== 8'h00) begin fails++; $display("[TB] FAIL midrst_rx_data got %h want 00", rx_data_o); end
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        spi_cs_i = 1'b1;
        repeat (8) @(negedge clk_i);
        checks++; if ((rx_count - rx0) + (fs_count - fs0) + (fe_count - fe0) + (ur_count - ur0) !== 0) begin
            fails++; $display("[TB] FAIL midrst_strobes got %0d want 0",
                              (rx_count - rx0) + (fs_count - fs0) + (fe_count - fe0) + (ur_count - ur0));
        end
        rx0 = rx_count;
        start_frame();
        spi_bits(8'h5A, 8, 1'b1, mi);
        end_frame();
        checks++; if (rx_count - rx0 !== 1) begin fails++; $display("[TB] FAIL midrst_next_count got %0d want 1", rx_count - rx0); end
        checks++; if (rx_data_o !== 8'h5A) begin fails++; $display("[TB] FAIL midrst_next_data got %h want 5a", rx_data_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m0, m1, m2;
        int rx0 = rx_count, ur0 = ur_count;
        @(negedge clk_i);
        tx_data_i  = 8'hC3;
        tx_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        start_frame();
        spi_bits(8'h01, 8, 1'b0, m0);
        spi_bits(8'hFF, 8, 1'b0, m1);
        spi_bits(8'h80, 8, 1'b1, m2);
        end_frame();
        tx_valid_i = 1'b0;
        checks++; if (rx_count - rx0 !== 3) begin fails++; $display("[TB] FAIL b2b_rx_count got %0d want 3", rx_count - rx0); end
        checks++; if (rx_log[rx0 % 16] !== 8'h01) begin fails++; $display("[TB] FAIL b2b_rx0 got %h want 01", rx_log[rx0 % 16]); end
        checks++; if (rx_log[(rx0 + 1) % 16] !== 8'hFF) begin fails++; $display("[TB] FAIL b2b_rx1 got %h want ff", rx_log[(rx0 + 1) % 16]); end
        checks++; if (rx_log[(rx0 + 2) % 16] !== 8'h80) begin fails++; $display("[TB] FAIL b2b_rx2 got %h want 80", rx_log[(rx0 + 2) % 16]); end
        checks++; if ({m0, m1, m2} !== {8'hC3, 8'hC3, 8'hC3}) begin fails++; $display("[TB] FAIL b2b_miso got %h %h %h want c3 c3 c3", m0, m1, m2); end
        checks++; if (ur_count - ur0 !== 0) begin fails++; $display("[TB] FAIL b2b_underrun got %0d want 0", ur_count - ur0); end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
